// File: rtl/seg7_scan_ctrl_if.sv
// Write-side bus of the seven-segment scan controller: the per-digit pattern
// write strobe and the commit request, as driven from the MCS GPO outputs.
interface seg7_scan_ctrl_if;
    logic       wr;
    logic [1:0] wadr;
    logic [7:0] wdat;
    logic       commit;

    modport master (output wr, wadr, wdat, commit);
    modport slave  (input  wr, wadr, wdat, commit);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner with double-buffered patterns
// committed on frame boundaries. SEG7_HEXDEC_EN selects hex decoding of WDAT.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_ctrl_if.slave   wbus,
    input  logic [3:0]        digen,
    output logic [7:0]        nseg,
    output logic [3:0]        nan,
    output logic              pend,
    output logic              frame
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} phase_t;
    // With no blanking gap the slot starts straight in DRIVE, even out of reset.
    localparam phase_t PHASE_RST = (BLANK_CYC > 0) ? BLANK : DRIVE;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [1:0]    idx_r;
    logic [1:0]    idx_nxt_s;
    phase_t        state_r;
    phase_t        state_nxt_s;
    logic [7:0]    shadow_r [4];
    logic [7:0]    disp_r [4];
    logic [7:0]    wr_pat_s;
    logic          wrap_s;
    logic          xfer_s;
    logic [7:0]    nseg_nxt_s;
    logic [3:0]    nan_nxt_s;
    logic [7:0]    nseg_r;
    logic [3:0]    nan_r;
    logic          pend_r;
    logic          frame_r;

`ifdef SEG7_HEXDEC_EN
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic unused_wdat_s;
    assign unused_wdat_s = ^wbus.wdat[6:4];

    // Decode the hex nibble; WDAT[7] set lights the (active-low) decimal point.
    always_comb begin
        wr_pat_s = {~wbus.wdat[7], hex_to_seg(wbus.wdat[3:0])};
    end
`else
    // Raw pattern path: the written byte is stored verbatim.
    always_comb begin
        wr_pat_s = wbus.wdat;
    end
`endif

    // Slot counter, digit index, phase and frame-boundary transfer decision.
    always_comb begin
        wrap_s = (cnt_r == CNT_LAST);
        if (wrap_s) begin
            cnt_nxt_s = '0;
            idx_nxt_s = idx_r + 2'd1;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
            idx_nxt_s = idx_r;
        end
        if (int'(cnt_nxt_s) < BLANK_CYC) begin
            state_nxt_s = BLANK;
        end else begin
            state_nxt_s = DRIVE;
        end
        xfer_s = wrap_s && (idx_r == 2'd3) && (pend_r || wbus.commit);
    end

    // Scan position and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            idx_r   <= 2'd0;
            state_r <= PHASE_RST;
        end else begin
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    // Shadow writes and the shadow-to-display commit at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= 8'hFF;
                disp_r[i]   <= 8'hFF;
            end
            pend_r  <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            if (wbus.wr) begin
                shadow_r[wbus.wadr] <= wr_pat_s;
            end
            if (xfer_s) begin
                for (int i = 0; i < 4; i++) begin
                    disp_r[i] <= shadow_r[i];
                end
                pend_r  <= 1'b0;
                frame_r <= 1'b1;
            end else begin
                pend_r  <= pend_r | wbus.commit;
                frame_r <= 1'b0;
            end
        end
    end

    // Pin drive for the current phase; a disabled digit stays dark in its slot.
    always_comb begin
        nseg_nxt_s = 8'hFF;
        nan_nxt_s  = 4'hF;
        case (state_r)
            BLANK: begin
                nseg_nxt_s = 8'hFF;
                nan_nxt_s  = 4'hF;
            end
            DRIVE: begin
                if (digen[idx_r]) begin
                    nseg_nxt_s = disp_r[idx_r];
                    nan_nxt_s  = ~(4'b0001 << idx_r);
                end else begin
                    nseg_nxt_s = 8'hFF;
                    nan_nxt_s  = 4'hF;
                end
            end
            default: begin
                nseg_nxt_s = 8'hFF;
                nan_nxt_s  = 4'hF;
            end
        endcase
    end

    // Registered segment and anode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nseg_r <= 8'hFF;
            nan_r  <= 4'hF;
        end else begin
            nseg_r <= nseg_nxt_s;
            nan_r  <= nan_nxt_s;
        end
    end

    assign nseg  = nseg_r;
    assign nan   = nan_r;
    assign pend  = pend_r;
    assign frame = frame_r;

endmodule
